split_rr_chain_arb: RTL
=======================

Name: split_rr_chain_arb

Overview:
- Parametrised round-robin arbiter for NCH request lanes.
- The per-lane priority chain is held in one packed-struct array: each lane's "blocked" field is computed from the previous lane's fields within the same variable. The chain is acyclic per bit but cyclic at variable level, so it exercises split_var under ENABLE_SPLIT_VAR.
- Registered one-hot grant plus index, any-request flag and grant counter.
- Used as a regression block for split-variable scheduling and as a generic arbiter.

Parameters:
- NCH, 4, number of request lanes; legal range 2..32.
- CNT_W, 8, width of the grant counter.
- IDX_W, $clog2(NCH), index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable for the current cycle
- req  input  NCH  request vector, bit k = lane k
- lock  input  1  hold current grant (only with SPLIT_RR_LOCK_EN; ignored otherwise)
- gnt  output  NCH  registered one-hot grant, all-zero when none
- gnt_vld  output  1  registered, equals |gnt
- gnt_idx  output  IDX_W  registered index of granted lane; holds last value when gnt_vld=0
- any_req  output  1  registered |req, sampled every cycle regardless of en
- gnt_cnt  output  CNT_W  number of grants issued, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, gnt_vld=0, gnt_idx=0, any_req=0, gnt_cnt=0, internal ptr=0. Reset release is synchronous to clk through normal flop behaviour.
- Combinational chain, each cycle:
  - rot = req rotated right by ptr, so lane ptr becomes chain position 0.
  - chain[k] is a packed struct {r, blk}, with r = rot[k].
  - blk[0] = 0; blk[k] = blk[k-1] | r[k-1].
  - win[k] = r[k] & !blk[k].
  - win is rotated left by ptr back to lane order, giving at most one bit set.
- Latency: gnt, gnt_vld and gnt_idx reflect req and en sampled at the previous rising edge (one cycle).
- Clock edge with en=1 and |req=1:
  - gnt <= win, gnt_vld <= 1, gnt_idx <= winning lane.
  - ptr <= (winning lane + 1) mod NCH, wrapping from NCH-1 to 0.
  - gnt_cnt <= gnt_cnt + 1, wrapping at all-ones.
- Clock edge with en=1 and req=0: gnt <= 0, gnt_vld <= 0; ptr, gnt_idx and gnt_cnt hold.
- Clock edge with en=0: gnt <= 0, gnt_vld <= 0; ptr, gnt_idx and gnt_cnt hold. any_req still updates.
- Fairness: any lane with continuous req is granted within NCH grant cycles.
- A request is never queued: dropping req before the sampling edge cancels it.
- Reset asserted mid-stream clears everything immediately. The first post-reset arbitration starts from lane 0.

Optional Feature:
- Macro: SPLIT_RR_LOCK_EN.
- Defined:
  - If lock=1, en=1, gnt_vld=1 and req[gnt_idx]=1 at the edge, the grant is re-issued to gnt_idx.
  - In that case ptr holds and gnt_cnt does not increment (a held grant is not a new grant).
  - If req[gnt_idx] has dropped, normal arbitration applies that edge.
- Undefined: the lock port exists but is ignored; behaviour is pure round-robin.

Decomposition:
- Package split_rr_pkg:
  - chain_lane_t, a packed struct {logic r; logic blk;}.
  - Function to rotate a vector by a given amount.
  - Function to convert one-hot to index.
- Sub-module split_rr_chain (combinational): inputs rot; output win. It holds the packed chain array, and that array is the split_var target.
- The top module holds ptr, the output registers and the lock logic.

Test Plan:
- Reset then req=4'b1111, en=1 held: gnt sequence 0001, 0010, 0100, 1000, 0001; gnt_cnt increments 1..5; gnt_vld=1 from the first edge after the first sample.
- req=4'b1010 from ptr=0: grants 0010, 1000, 0010; lanes 0 and 2 never granted.
- en=0 for 3 cycles with req=4'b0100: gnt=0, gnt_vld=0, any_req=1, gnt_cnt unchanged. On en=1, gnt=0100 one cycle later.
- CNT_W=2 with 5 grants: gnt_cnt goes 1, 2, 3, 0, 1.
- rst_n pulsed low mid-cycle while gnt=1000: all outputs zero immediately without a clock edge. Next grant with req=4'b1111 is 0001.
- SPLIT_RR_LOCK_EN with lock=1 and req=4'b0011 after a grant of 0001: gnt stays 0001 and gnt_cnt is frozen. Drop req[0]: the next grant is 0010.

Source files
------------

// File: rtl/split_rr_pkg.sv
// Shared types and helpers for the split-variable round-robin arbiter.
// Helpers work on 32-bit vectors; callers zero-extend narrower lanes.
package split_rr_pkg;

  localparam int MAX_LANES = 32;

  typedef struct packed {
    logic r;
    logic blk;
  } chain_lane_t;

  // Rotate right by amt within the low n bits, so bit amt lands in position 0.
  function automatic logic [31:0] rot_right(input logic [31:0] v,
                                            input logic [4:0] amt,
                                            input int n);
    logic [31:0] res;
    logic [4:0]  src;
    res = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < n) begin
        src = 5'((k + int'(amt)) % n);
        res[k] = v[src];
      end
    end
    return res;
  endfunction

  // Inverse of rot_right: position 0 goes back to bit amt.
  function automatic logic [31:0] rot_left(input logic [31:0] v,
                                           input logic [4:0] amt,
                                           input int n);
    logic [31:0] res;
    logic [4:0]  dst;
    res = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (k < n) begin
        dst = 5'((k + int'(amt)) % n);
        res[dst] = v[k];
      end
    end
    return res;
  endfunction

  function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (v[k]) idx = idx | 5'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/split_rr_chain.sv
// Combinational priority chain in rotated lane order: the first requester
// at or after position 0 wins.
module split_rr_chain
  import split_rr_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] rot,
  output logic [NCH-1:0] win
);

  // Each lane's blk depends on the previous lane of the same packed array.
  chain_lane_t [NCH-1:0] chain;

  always_comb begin
    chain = '0;
    win   = '0;
    for (int k = 0; k < NCH; k++) begin
      chain[k].r = rot[k];
    end
    chain[0].blk = 1'b0;
    for (int k = 1; k < NCH; k++) begin
      chain[k].blk = chain[k-1].blk | chain[k-1].r;
    end
    for (int k = 0; k < NCH; k++) begin
      win[k] = chain[k].r & ~chain[k].blk;
    end
  end

endmodule

// File: rtl/split_rr_chain_arb.sv
// Round-robin arbiter top: pointer, registered grant outputs and grant counter.
// Optional grant hold via `define SPLIT_RR_LOCK_EN (lock port ignored otherwise).
module split_rr_chain_arb
  import split_rr_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic             lock,
  output logic [NCH-1:0]   gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_req,
  output logic [CNT_W-1:0] gnt_cnt
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] win_idx;
  logic [NCH-1:0]   rot;
  logic [NCH-1:0]   win_rot;
  logic [NCH-1:0]   win;
  logic [31:0]      req_wide;
  logic [31:0]      rot_wide;
  logic [31:0]      win_wide;
  logic [4:0]       idx_wide;
  logic             hold;

  always_comb begin
    req_wide = '0;
    req_wide[NCH-1:0] = req;
    rot_wide = rot_right(req_wide, 5'(ptr), NCH);
    rot = rot_wide[NCH-1:0];
  end

  split_rr_chain #(.NCH(NCH)) u_chain (
    .rot (rot),
    .win (win_rot)
  );

  always_comb begin
    win_wide = '0;
    win_wide[NCH-1:0] = win_rot;
    win_wide = rot_left(win_wide, 5'(ptr), NCH);
    win = win_wide[NCH-1:0];
    idx_wide = onehot_to_idx(win_wide);
    win_idx = idx_wide[IDX_W-1:0];
    if (win_idx == IDX_W'(NCH - 1)) ptr_next = '0;
    else                            ptr_next = win_idx + 1'b1;
  end

`ifdef SPLIT_RR_LOCK_EN
  // A held grant re-issues the current lane only while it keeps requesting.
  assign hold = lock & en & gnt_vld & req[gnt_idx];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold = 1'b0;
`endif

  logic unused_wide;
  assign unused_wide = ^{rot_wide, win_wide, idx_wide};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_idx <= '0;
      any_req <= 1'b0;
      gnt_cnt <= '0;
      ptr     <= '0;
    end else begin
      any_req <= |req;
      if (en && (|req)) begin
        gnt_vld <= 1'b1;
        if (!hold) begin
          gnt     <= win;
          gnt_idx <= win_idx;
          ptr     <= ptr_next;
          gnt_cnt <= gnt_cnt + 1'b1;
        end
      end else begin
        gnt     <= '0;
        gnt_vld <= 1'b0;
      end
    end
  end

endmodule
